// File: rtl/pc_gen.sv
// Program-counter generator: boot bubble, sequential fetch, and branch redirect buffering.
// Optional macro PCGEN_MISALIGN_CHK_EN halts on misaligned redirect targets instead of masking them.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        fetch_ready,
  input  logic        pc_b_j,
  input  logic [31:0] dnpc,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        pc_wrong,
  output logic        redirect_pending,
  output logic        misalign
);

  typedef enum logic [1:0] {BOOT, RUN, REDIR, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        fire;
  logic [31:0] redir_tgt;
  logic        redir_bad;

`ifdef PCGEN_MISALIGN_CHK_EN
  assign redir_tgt = dnpc;
  assign redir_bad = |dnpc[1:0];
`else
  assign redir_tgt = dnpc & 32'hFFFF_FFFC;
  assign redir_bad = 1'b0;
`endif

  assign fire = pc_valid & fetch_ready & ~stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (pc_b_j) begin
          if (redir_bad) begin
            state_d = HALT;
          end else if (fire) begin
            pc_d = redir_tgt;
          end else begin
            tgt_d   = redir_tgt;
            state_d = REDIR;
          end
        end else if (fire) begin
          pc_d = pc_q + 32'd4;
        end
      end
      // Younger redirects seen here are themselves wrong-path, so pc_b_j is ignored.
      REDIR: begin
        if (fire) begin
          pc_d    = tgt_q;
          state_d = RUN;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  assign pc               = pc_q;
  assign pc_valid         = (state_q == RUN) || (state_q == REDIR);
  assign pc_wrong         = (state_q == REDIR);
  assign redirect_pending = (state_q == REDIR);
`ifdef PCGEN_MISALIGN_CHK_EN
  assign misalign         = (state_q == HALT);
`else
  assign misalign         = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_gen;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
`ifdef PCGEN_MISALIGN_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, fetch_ready = 1'b0, pc_b_j = 1'b0;
  logic [31:0] dnpc = 32'h0;
  logic [31:0] pc;
  logic        pc_valid, pc_wrong, redirect_pending, misalign;

  int compared = 0;
  int mismatched = 0;

  // obs/exp layout: {pc[35:4], valid[3], wrong[2], pending[1], misalign[0]}
  logic [35:0] obs_vec, exp_vec;

  // Behavioural model: bubble flag, pending redirect flag, halt flag, pc, target.
  bit          m_boot, m_pend, m_halt;
  logic [31:0] m_pc, m_tgt;

  pc_gen #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .pc_b_j(pc_b_j), .dnpc(dnpc), .pc(pc), .pc_valid(pc_valid),
    .pc_wrong(pc_wrong), .redirect_pending(redirect_pending), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_boot = 1; m_pend = 0; m_halt = 0; m_pc = RST_PC; m_tgt = 32'h0;
  endtask

  task automatic assert_rst();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    model_reset();
    obs_vec = {pc, pc_valid, pc_wrong, redirect_pending, misalign};
  endtask

  task automatic release_rst();
    #2 rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, sample outputs at negedge, advance model at posedge.
  task automatic cyc(input logic st, input logic fr, input logic bj, input logic [31:0] dn);
    bit fire, nb, np, nh;
    logic [31:0] npc, nt, tgt;
    stall = st; fetch_ready = fr; pc_b_j = bj; dnpc = dn;
    @(negedge clk);
    obs_vec = {pc, pc_valid, pc_wrong, redirect_pending, misalign};
    exp_vec = {m_pc, ~m_boot & ~m_halt, m_pend, m_pend, m_halt};
    $display("cyc t=%0t st=%b fr=%b bj=%b dn=%h -> pc=%h v=%b w=%b p=%b m=%b",
             $time, st, fr, bj, dn, pc, pc_valid, pc_wrong, redirect_pending, misalign);
    fire = !m_boot && !m_halt && fr && !st;
    nb = 0; np = m_pend; nh = m_halt; npc = m_pc; nt = m_tgt;
    tgt = CHK_EN ? dn : {dn[31:2], 2'b00};
    if (m_boot || m_halt) begin
      // bubble or halted: nothing moves
    end else if (m_pend) begin
      if (fire) begin npc = m_tgt; np = 0; end
    end else if (bj) begin
      if (CHK_EN && dn[1:0] != 2'b00) nh = 1;
      else if (fire) npc = tgt;
      else begin np = 1; nt = tgt; end
    end else if (fire) begin
      npc = m_pc + 32'd4;
    end
    @(posedge clk); #1;
    m_boot = nb; m_pend = np; m_halt = nh; m_pc = npc; m_tgt = nt;
  endtask

  // Reset, boot bubble, then four fires: presented pc becomes 8000_0010.
  task automatic advance_to_10();
    assert_rst();
    release_rst();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    assert_rst();
    if (obs_vec !== {RST_PC, 4'b0000}) begin
      mismatched++; $display("FAIL reset_async got %h want %h", obs_vec, {RST_PC, 4'b0000});
    end
    compared++;
    @(posedge clk); #1;
    obs_vec = {pc, pc_valid, pc_wrong, redirect_pending, misalign};
    if (obs_vec !== {RST_PC, 4'b0000}) begin
      mismatched++; $display("FAIL reset_hold got %h want %h", obs_vec, {RST_PC, 4'b0000});
    end
    compared++;
    release_rst();
    cyc(1'b0, 1'b1, 1'b1, 32'h1234_5678);
    if (obs_vec !== {RST_PC, 4'b0000}) begin
      mismatched++; $display("FAIL boot_bubble got %h want %h", obs_vec, {RST_PC, 4'b0000});
    end
    compared++;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    if (obs_vec !== {RST_PC, 4'b1000}) begin
      mismatched++; $display("FAIL boot_ignores_bj got %h want %h", obs_vec, {RST_PC, 4'b1000});
    end
    compared++;
  endtask

  task automatic test_sequential();
    logic [35:0] want [4];
    want[0] = {RST_PC, 4'b0000};
    want[1] = {32'h8000_0000, 4'b1000};
    want[2] = {32'h8000_0004, 4'b1000};
    want[3] = {32'h8000_0008, 4'b1000};
    assert_rst();
    release_rst();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      if (obs_vec !== want[i]) begin
        mismatched++; $display("FAIL sequential[%0d] got %h want %h", i, obs_vec, want[i]);
      end
      compared++;
    end
  endtask

  task automatic test_redirect_held();
    advance_to_10();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, (i == 2), 32'h8000_0100);
      if (obs_vec !== {32'h8000_0010, 1'b1, (i >= 3), (i >= 3), 1'b0}) begin
        mismatched++;
        $display("FAIL redirect_held[%0d] got %h want %h", i, obs_vec,
                 {32'h8000_0010, 1'b1, (i >= 3), (i >= 3), 1'b0});
      end
      compared++;
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    if (obs_vec !== {32'h8000_0100, 4'b1000}) begin
      mismatched++; $display("FAIL redirect_handoff got %h want %h", obs_vec, {32'h8000_0100, 4'b1000});
    end
    compared++;
  endtask

  task automatic test_redirect_ignored();
    advance_to_10();
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0100);
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0200);
    cyc(1'b0, 1'b1, 1'b1, 32'h8000_0300);
    if (obs_vec !== {32'h8000_0010, 4'b1110}) begin
      mismatched++; $display("FAIL redir_wrongpath got %h want %h", obs_vec, {32'h8000_0010, 4'b1110});
    end
    compared++;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    if (obs_vec !== {32'h8000_0100, 4'b1000}) begin
      mismatched++; $display("FAIL first_redirect_wins got %h want %h", obs_vec, {32'h8000_0100, 4'b1000});
    end
    compared++;
  endtask

  task automatic test_direct_and_wrap();
    advance_to_10();
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    if (obs_vec !== {32'hFFFF_FFFC, 4'b1000}) begin
      mismatched++; $display("FAIL direct_redirect got %h want %h", obs_vec, {32'hFFFF_FFFC, 4'b1000});
    end
    compared++;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    if (obs_vec !== {32'h0000_0000, 4'b1000}) begin
      mismatched++; $display("FAIL wrap got %h want %h", obs_vec, {32'h0000_0000, 4'b1000});
    end
    compared++;
  endtask

  task automatic test_stall_capture();
    advance_to_10();
    cyc(1'b1, 1'b1, 1'b1, 32'h8000_0200);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    if (obs_vec !== {32'h8000_0010, 4'b1110}) begin
      mismatched++; $display("FAIL stall_capture got %h want %h", obs_vec, {32'h8000_0010, 4'b1110});
    end
    compared++;
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    if (obs_vec !== {32'h8000_0200, 4'b1000}) begin
      mismatched++; $display("FAIL stall_handoff got %h want %h", obs_vec, {32'h8000_0200, 4'b1000});
    end
    compared++;
  endtask

  task automatic test_misalign();
    logic [35:0] want;
    advance_to_10();
    cyc(1'b0, 1'b1, 1'b1, 32'h8000_0102);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      if (CHK_EN) want = {32'h8000_0010, 4'b0001};
      else        want = {32'h8000_0100 + 32'(4 * i), 4'b1000};
      if (obs_vec !== want) begin
        mismatched++; $display("FAIL misalign[%0d] got %h want %h", i, obs_vec, want);
      end
      compared++;
    end
  endtask

  task automatic test_reset_in_redir();
    advance_to_10();
    cyc(1'b0, 1'b0, 1'b1, 32'h8000_0100);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    assert_rst();
    if (obs_vec !== {RST_PC, 4'b0000}) begin
      mismatched++; $display("FAIL reset_in_redir got %h want %h", obs_vec, {RST_PC, 4'b0000});
    end
    compared++;
    release_rst();
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    if (obs_vec !== {32'h8000_0004, 4'b1000}) begin
      mismatched++; $display("FAIL target_discarded got %h want %h", obs_vec, {32'h8000_0004, 4'b1000});
    end
    compared++;
  endtask

  task automatic test_random();
    logic [31:0] dn;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        assert_rst();
        release_rst();
      end
      dn = $urandom;
      if ($urandom_range(7) != 0) dn[1:0] = 2'b00;
      cyc($urandom_range(3) == 0, $urandom_range(9) < 7, $urandom_range(6) == 0, dn);
      if (obs_vec !== exp_vec) begin
        mismatched++; $display("FAIL random[%0d] got %h want %h", i, obs_vec, exp_vec);
      end
      compared++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_redirect_held();
    test_redirect_ignored();
    test_direct_and_wrap();
    test_stall_capture();
    test_misalign();
    test_reset_in_redir();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
